// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle for the instruction cache.
// Ports: imemREN/imemaddr/iflush in, ihit/imemload out (datapath side);
//        iREN/iaddr out, iwait/iload in (memory side); hit/miss counters out.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // The cache itself.
  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  // Datapath plus memory controller, seen as one environment.
  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a two-state fill FSM.
// Ports: CLK, RST (async active-high), bus (icache_if.slave): fetch request/response,
//        memory read port, whole-cache flush, saturating hit/miss counters.
module icache #(
  parameter int NSETS = 16
) (
  input  logic      CLK,
  input  logic      RST,
  icache_if.slave   bus
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state, next_state;
  logic [NSETS-1:0]  valid;
  logic [TW-1:0]     tag_mem  [NSETS];
  logic [31:0]       data_mem [NSETS];
  logic [31:0]       fill_addr;
  logic [31:0]       hit_count, miss_count;

  logic [IW-1:0]     req_idx, fill_idx;
  logic [TW-1:0]     req_tag, fill_tag;
  logic              hit, miss;
  logic              ihit, iren, fill_done;
  logic [31:0]       imemload;
  logic [1:0]        unused_offset;

  assign req_idx       = bus.imemaddr[IW+1:2];
  assign req_tag       = bus.imemaddr[31:IW+2];
  assign fill_idx      = fill_addr[IW+1:2];
  assign fill_tag      = fill_addr[31:IW+2];
  assign unused_offset = bus.imemaddr[1:0];

  // A flush cycle is neither a hit nor a miss: the lookup it would see is about to vanish.
  assign hit  = bus.imemREN && valid[req_idx] && (tag_mem[req_idx] == req_tag)
                && (state == IDLE) && !bus.iflush;
  assign miss = bus.imemREN && !hit && !bus.iflush && (state == IDLE);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss) next_state = FILL;
      FILL:    if (!bus.iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ihit      = 1'b0;
    imemload  = '0;
    iren      = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        ihit = hit;
        if (hit) imemload = data_mem[req_idx];
      end
      FILL: begin
        iren      = 1'b1;
        fill_done = !bus.iwait;
      end
      default: ;
    endcase
  end

  // Frame array; a flush on the fill-completion edge overrides the new valid bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= '0;
      for (int i = 0; i < NSETS; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (fill_done) begin
        tag_mem[fill_idx]  <= fill_tag;
        data_mem[fill_idx] <= bus.iload;
        valid[fill_idx]    <= 1'b1;
      end
      if (bus.iflush) valid <= '0;
    end
  end

  // Fill address is captured once at miss time so fetch-address churn cannot disturb the fill.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       fill_addr <= '0;
    else if (miss) fill_addr <= {bus.imemaddr[31:2], 2'b00};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != 32'hFFFF_FFFF))  hit_count  <= hit_count + 32'd1;
      if (miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end

  assign bus.ihit       = ihit;
  assign bus.imemload   = imemload;
  assign bus.iREN       = iren;
  assign bus.iaddr      = fill_addr;
  assign bus.hit_count  = hit_count;
  assign bus.miss_count = miss_count;
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected hit data and fill addresses,
// a negedge monitor pops and compares whenever ihit or a fill completion appears.
module tb_icache;
  logic CLK;
  logic RST;
  icache_if bus ();

  icache #(.NSETS(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors;
  int miscompares;
  int exp_hit;
  int exp_miss;
  logic [31:0] hit_q  [$];
  logic [31:0] fill_q [$];

  // Backing-store contents: a word derived from its own address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h3C01_0001 ^ {a[15:0], a[15:0]};
  endfunction

  assign bus.iload = memword(bus.iaddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every presented output against the scoreboard queues.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.ihit) begin
        chk("ihit_iren_exclusive", 32'(bus.iREN), 32'd0);
        if (hit_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_hit: imemload 0x%08h with nothing expected", bus.imemload);
        end else begin
          chk("imemload", bus.imemload, hit_q.pop_front());
        end
      end else begin
        chk("imemload_zero_on_miss", bus.imemload, 32'd0);
      end
      if (bus.iREN && !bus.iwait) begin
        if (fill_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_fill: iaddr 0x%08h with nothing expected", bus.iaddr);
        end else begin
          chk("fill_iaddr", bus.iaddr, fill_q.pop_front());
        end
      end
    end
  end

  // Request one word and hold it until ihit; nw = wait cycles the memory inserts.
  // Starts and ends at posedge+1.
  task automatic fetch(input logic [31:0] a, input bit miss, input int nw);
    int  fc = 0;
    int  n = 0;
    bit  done = 0;
    bit  first_hit = 0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    bus.iwait    = 1'b0;
    hit_q.push_back(memword({a[31:2], 2'b00}));
    exp_hit++;
    if (miss) begin
      fill_q.push_back({a[31:2], 2'b00});
      exp_miss++;
    end
    while (!done) begin
      if (bus.iREN) begin
        fc++;
        bus.iwait = (fc <= nw);
      end
      @(negedge CLK);
      if (n == 0) first_hit = bus.ihit;
      if (bus.ihit) done = 1;
      n++;
      @(posedge CLK); #1;
      if (!done && n > 40 + nw) begin
        vectors++;
        miscompares++;
        $display("FAIL fetch_timeout: addr 0x%08h got no ihit after %0d cycles", a, n);
        hit_q.delete();
        fill_q.delete();
        done = 1;
      end
    end
    chk($sformatf("first_cycle_hit_%08h", a), 32'(first_hit), 32'(!miss));
  endtask

  // Advance until the FSM is in FILL (iREN visible). Starts and ends at posedge+1.
  task automatic wait_iren();
    int n = 0;
    while (!bus.iREN && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!bus.iREN) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_iren_timeout: iREN never rose");
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_hit_count"},  bus.hit_count,  32'(exp_hit));
    chk({tag, "_miss_count"}, bus.miss_count, 32'(exp_miss));
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.imemREN = 1'b0;
    bus.iwait   = 1'b0;
    bus.iflush  = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    @(posedge CLK); #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_hit = 0; exp_miss = 0;
    RST = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iflush = 1'b0; bus.iwait = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ihit", 32'(bus.ihit), 32'd0);
    chk("rst_imemload", bus.imemload, 32'd0);
    chk("rst_iren", 32'(bus.iREN), 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'd0);
    check_counters("rst");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // First fetch: miss, fill with no wait, hit 0x3C010001.
    fetch(32'h0, 1'b1, 0);
    check_counters("first");

    // Sequential 16 words, then a second pass that must hit every cycle.
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), (i != 0), 0);
    check_counters("pass1");
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), 1'b0, 0);
    check_counters("pass2");
    chk("pass2_miss_count", bus.miss_count, 32'd16);

    // Idle cycles: no hits, no misses, no fill.
    bus.imemREN = 1'b0;
    bus.imemaddr = 32'h0000_0100;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_iren", 32'(bus.iREN), 32'd0);
    check_counters("idle");

    // Conflict on index 1.
    apply_reset();
    fetch(32'h04, 1'b1, 0);
    fetch(32'h44, 1'b1, 0);
    fetch(32'h04, 1'b1, 2);
    chk("conflict_miss_count", bus.miss_count, 32'd3);
    check_counters("conflict");

    // Long fill of 0x10 while the fetch address moves to 0x80.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h10; bus.iwait = 1'b1;
    fill_q.push_back(32'h10);
    exp_miss++;
    @(posedge CLK); #1;
    wait_iren();
    bus.imemaddr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_iren", 32'(bus.iREN), 32'd1);
      chk("stall_iaddr", bus.iaddr, 32'h10);
      if (i < 4) begin
        @(posedge CLK); #1;
      end
    end
    bus.iwait = 1'b0;
    @(posedge CLK); #1;
    fetch(32'h80, 1'b1, 0);
    fetch(32'h10, 1'b0, 0);
    check_counters("stall");

    // Flush coincident with the completion of a fill of 0x08.
    fetch(32'h00, 1'b1, 0);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h08; bus.iwait = 1'b0;
    fill_q.push_back(32'h08);
    exp_miss++;
    @(posedge CLK); #1;
    wait_iren();
    bus.iflush = 1'b1;
    @(posedge CLK); #1;
    bus.iflush = 1'b0;
    chk("flush_iren_after", 32'(bus.iREN), 32'd0);
    fetch(32'h08, 1'b1, 0);
    fetch(32'h00, 1'b1, 0);
    check_counters("flush");

    // Reset asserted in the middle of a stalled fill.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h14; bus.iwait = 1'b1;
    @(posedge CLK); #1;
    wait_iren();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    exp_hit = 0; exp_miss = 0;
    chk("midfill_rst_iren", 32'(bus.iREN), 32'd0);
    chk("midfill_rst_iaddr", bus.iaddr, 32'd0);
    chk("midfill_rst_ihit", 32'(bus.ihit), 32'd0);
    check_counters("midfill_rst");
    bus.imemREN = 1'b0; bus.iwait = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    fetch(32'h00, 1'b1, 0);
    fetch(32'h08, 1'b1, 0);
    fetch(32'h14, 1'b1, 1);
    check_counters("after_rst");

    bus.imemREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("hit_q_drained", 32'(hit_q.size()), 32'd0);
    chk("fill_q_drained", 32'(fill_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
